// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode-side signals of the fetch stage.
//   imem_req/imem_addr    fetch request toward instruction memory
//   imem_ready/imem_rdata memory completion and returned word
//   instr_valid/instr_ready, instr, instr_pc, instr_pc_plus1  decode handshake
//   redirect/redirect_pc  branch/jump target from the datapath
// master: the fetch unit; slave: memory + decode side.
interface fetch_unit_if #(
   parameter int unsigned PC_W = 5
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic [PC_W-1:0] instr_pc;
   logic [PC_W-1:0] instr_pc_plus1;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus1,
      input  imem_ready, imem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus1,
      output imem_ready, imem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the word-addressed PC, issues one
// request at a time to a variable-latency instruction memory, buffers one
// returned instruction with its PC and offers it to decode via valid/ready.
// Redirects squash the buffered instruction and any in-flight fetch.
// Ports:
//   CLK    sole clock
//   RST_N  asynchronous active-low reset
//   bus    fetch_unit_if master modport (memory + decode + redirect signals)
module fetch_unit #(
   parameter int unsigned PC_W     = 5,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          CLK,
   input  logic          RST_N,
   fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_FULL,
      S_DRAIN
   } state_t;

   state_t          state, state_nx;
   logic [PC_W-1:0] pc, pc_nx;
   logic [PC_W-1:0] target, target_nx;
   logic [31:0]     instr_q;
   logic [PC_W-1:0] instr_pc_q;
   logic            load;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_FETCH;
         pc         <= PC_W'(RESET_PC);
         target     <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         target <= target_nx;
         if (load) begin
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc;
         end
      end
   end

   // DRAIN keeps the abandoned request on the bus (a request is never
   // withdrawn) and remembers the newest redirect target until it completes.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      target_nx = target;
      load      = 1'b0;
      unique case (state)
         S_FETCH: begin
            if (bus.imem_ready) begin
               if (bus.redirect) begin
                  pc_nx = bus.redirect_pc;
               end else begin
                  load     = 1'b1;
                  pc_nx    = pc + 1'b1;
                  state_nx = S_FULL;
               end
            end else if (bus.redirect) begin
               target_nx = bus.redirect_pc;
               state_nx  = S_DRAIN;
            end
         end
         S_FULL: begin
            if (bus.redirect) begin
               pc_nx    = bus.redirect_pc;
               state_nx = S_FETCH;
            end else if (bus.instr_ready) begin
               state_nx = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (bus.redirect) begin
               target_nx = bus.redirect_pc;
            end
            if (bus.imem_ready) begin
               pc_nx    = bus.redirect ? bus.redirect_pc : target;
               state_nx = S_FETCH;
            end
         end
         default: begin
            state_nx = S_FETCH;
         end
      endcase
   end

   // Request is gated by RST_N so it drops the moment reset is asserted.
   assign bus.imem_req       = RST_N && (state != S_FULL);
   assign bus.imem_addr      = pc;
   assign bus.instr_valid    = (state == S_FULL);
   assign bus.instr          = instr_q;
   assign bus.instr_pc       = instr_pc_q;
   assign bus.instr_pc_plus1 = instr_pc_q + 1'b1;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A cycle table drives a
// RESET_PC=0 instance; a hand-written sequence drives a RESET_PC=30 instance
// through PC wrap and asynchronous mid-operation resets.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst0 = 1'b0;
   logic rst1 = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.PC_W(5)) b0 ();
   fetch_unit_if #(.PC_W(5)) b1 ();

   fetch_unit #(.PC_W(5), .RESET_PC(0))  u0 (.CLK(clk), .RST_N(rst0), .bus(b0.master));
   fetch_unit #(.PC_W(5), .RESET_PC(30)) u1 (.CLK(clk), .RST_N(rst1), .bus(b1.master));

   typedef struct {
      logic        rst;
      logic        mr;
      logic [31:0] md;
      logic        ir;
      logic        rd;
      logic [4:0]  rpc;
      logic        req;
      logic [4:0]  addr;
      logic        val;
      logic [31:0] ins;
      logic [4:0]  ipc;
   } vec_t;

   vec_t tbl[32];

   function automatic vec_t mk(logic rst, logic mr, logic [31:0] md, logic ir,
                               logic rd, logic [4:0] rpc, logic req,
                               logic [4:0] addr, logic val, logic [31:0] ins,
                               logic [4:0] ipc);
      vec_t v;
      v.rst = rst; v.mr = mr; v.md = md; v.ir = ir; v.rd = rd; v.rpc = rpc;
      v.req = req; v.addr = addr; v.val = val; v.ins = ins; v.ipc = ipc;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   initial begin
      logic [4:0] ep;
      logic [4:0] p1;
      logic       bad;

      b0.imem_ready = 0; b0.imem_rdata = '0; b0.instr_ready = 0;
      b0.redirect = 0; b0.redirect_pc = '0;
      b1.imem_ready = 0; b1.imem_rdata = '0; b1.instr_ready = 0;
      b1.redirect = 0; b1.redirect_pc = '0;

      // reset held 3 cycles
      for (int i = 0; i < 3; i++) tbl[i] = mk(0,0,0,0,0,0, 0,0,0,0,0);
      // zero-latency stream
      tbl[3]  = mk(1,1,32'h20000000,1,0,0,  1,0,0,0,0);
      tbl[4]  = mk(1,1,32'h0,1,0,0,         0,0,1,32'h20000000,0);
      tbl[5]  = mk(1,1,32'h20000001,1,0,0,  1,1,0,0,0);
      tbl[6]  = mk(1,0,32'h0,1,0,0,         0,0,1,32'h20000001,1);
      tbl[7]  = mk(1,1,32'h20000002,1,0,0,  1,2,0,0,0);
      // backpressure: 4 stalled cycles at instr_pc=2, memory ready ignored
      for (int i = 8; i < 12; i++) tbl[i] = mk(1,1,32'hDEADBEEF,0,0,0, 0,0,1,32'h20000002,2);
      tbl[12] = mk(1,0,32'h0,1,0,0,         0,0,1,32'h20000002,2);
      // 3-cycle memory latency at addr 3
      tbl[13] = mk(1,0,32'h0,1,0,0,         1,3,0,0,0);
      tbl[14] = mk(1,0,32'h0,1,0,0,         1,3,0,0,0);
      tbl[15] = mk(1,1,32'h20000003,1,0,0,  1,3,0,0,0);
      tbl[16] = mk(1,0,32'h0,1,0,0,         0,0,1,32'h20000003,3);
      tbl[17] = mk(1,1,32'h20000004,1,0,0,  1,4,0,0,0);
      // redirect to 12 wins over consume at instr_pc=4
      tbl[18] = mk(1,0,32'h0,1,1,12,        0,0,1,32'h20000004,4);
      tbl[19] = mk(1,1,32'h2000000C,1,0,0,  1,12,0,0,0);
      tbl[20] = mk(1,0,32'h0,1,0,0,         0,0,1,32'h2000000C,12);
      // redirect coincident with ready in FETCH -> addr 5
      tbl[21] = mk(1,1,32'h2000000D,1,1,5,  1,13,0,0,0);
      // redirect 17 then 9 while addr 5 waits
      tbl[22] = mk(1,0,32'h0,1,1,17,        1,5,0,0,0);
      tbl[23] = mk(1,0,32'h0,1,1,9,         1,5,0,0,0);
      tbl[24] = mk(1,0,32'h0,1,0,0,         1,5,0,0,0);
      tbl[25] = mk(1,1,32'h20000005,1,0,0,  1,5,0,0,0);
      tbl[26] = mk(1,1,32'h20000009,1,0,0,  1,9,0,0,0);
      tbl[27] = mk(1,0,32'h0,1,0,0,         0,0,1,32'h20000009,9);
      // DRAIN with redirect in the same cycle as ready
      tbl[28] = mk(1,0,32'h0,1,1,20,        1,10,0,0,0);
      tbl[29] = mk(1,1,32'h2000000A,1,1,25, 1,10,0,0,0);
      tbl[30] = mk(1,1,32'h20000019,1,0,0,  1,25,0,0,0);
      tbl[31] = mk(1,0,32'h0,1,0,0,         0,0,1,32'h20000019,25);

      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rst0 = tbl[i].rst;
         b0.imem_ready = tbl[i].mr; b0.imem_rdata = tbl[i].md;
         b0.instr_ready = tbl[i].ir; b0.redirect = tbl[i].rd;
         b0.redirect_pc = tbl[i].rpc;
         #1;
         p1 = tbl[i].ipc + 5'd1;
         bad = (b0.imem_req !== tbl[i].req) ||
               (tbl[i].req && (b0.imem_addr !== tbl[i].addr)) ||
               (b0.instr_valid !== tbl[i].val) ||
               (tbl[i].val && ((b0.instr !== tbl[i].ins) ||
                               (b0.instr_pc !== tbl[i].ipc) ||
                               (b0.instr_pc_plus1 !== p1)));
         nvec++;
         if (bad) begin
            nerr++;
            $display("FAIL vec%0d: req=%b addr=%0d valid=%b instr=%h pc=%0d pc1=%0d expected req=%b addr=%0d valid=%b instr=%h pc=%0d pc1=%0d",
                     i, b0.imem_req, b0.imem_addr, b0.instr_valid, b0.instr,
                     b0.instr_pc, b0.instr_pc_plus1, tbl[i].req, tbl[i].addr,
                     tbl[i].val, tbl[i].ins, tbl[i].ipc, p1);
         end
      end

      // RESET_PC=30: wrap through 31 -> 0 -> 1
      repeat (2) @(negedge clk);
      #1;
      chk("rst1_req", b1.imem_req, 0);
      chk("rst1_valid", b1.instr_valid, 0);
      @(negedge clk);
      rst1 = 1; b1.imem_ready = 1; b1.instr_ready = 1;
      for (int k = 0; k < 4; k++) begin
         ep = 5'(30 + k);
         b1.imem_rdata = 32'h20000000 + 32'(ep);
         #1;
         chk("wrap_req", b1.imem_req, 1);
         chk("wrap_addr", b1.imem_addr, 32'(ep));
         @(negedge clk);
         #1;
         p1 = ep + 5'd1;
         chk("wrap_valid", b1.instr_valid, 1);
         chk("wrap_pc", b1.instr_pc, 32'(ep));
         chk("wrap_instr", b1.instr, 32'h20000000 + 32'(ep));
         chk("wrap_pc1", b1.instr_pc_plus1, 32'(p1));
         @(negedge clk);
      end
      // reset while waiting on addr 2
      b1.imem_ready = 0;
      #1;
      chk("wait_req", b1.imem_req, 1);
      chk("wait_addr", b1.imem_addr, 2);
      #2 rst1 = 0;
      #1;
      chk("midrst_req", b1.imem_req, 0);
      chk("midrst_valid", b1.instr_valid, 0);
      @(negedge clk);
      rst1 = 1; b1.imem_ready = 1; b1.instr_ready = 0;
      b1.imem_rdata = 32'h2000001E;
      #1;
      chk("restart_req", b1.imem_req, 1);
      chk("restart_addr", b1.imem_addr, 30);
      @(negedge clk);
      #1;
      chk("full_valid", b1.instr_valid, 1);
      chk("full_pc", b1.instr_pc, 30);
      // reset while holding a buffered instruction
      #2 rst1 = 0;
      #1;
      chk("fullrst_valid", b1.instr_valid, 0);
      chk("fullrst_req", b1.imem_req, 0);
      @(negedge clk);
      rst1 = 1;
      #1;
      chk("rerun_req", b1.imem_req, 1);
      chk("rerun_addr", b1.imem_addr, 30);
      chk("rerun_valid", b1.instr_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
